microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Sequences the control unit's microstore: holds the current microstore address (state register) and computes the next one each cycle.
- Inputs: next-state control fields of the current control word, the instruction-encoder target, condition flags and the memory-operation-complete handshake.
- Provides conditional branching, a one-deep microsubroutine return register, and a MOC wait with timeout.
- Sits between the microstore output fields and the microstore address input.

Parameters:
- STATE_W, 10, width of microstore address.
- ERR_STATE, 10'd48, state entered on MOC timeout or return-register misuse.
- MOC_TIMEOUT, 16, max cycles waited for moc before error (must be 1..255).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- stall  input  1  freeze sequencer: no register changes while high.
- ns_sel  input  3  next-state select field of current control word.
- cr  input  STATE_W  constant target field of current control word.
- cond_sel  input  2  flag select: 00 Z, 01 N, 10 C, 11 V.
- inv  input  1  invert selected condition.
- flags  input  4  {V,C,N,Z} from the status register.
- enc_state  input  STATE_W  decode target from the instruction encoder.
- moc  input  1  memory operation complete.
- state_addr  output  STATE_W  registered current state; drives microstore address.
- moc_wait  output  1  combinational: ns_sel==WAIT_MOC and moc==0 and !stall.
- ret_valid  output  1  return register holds a valid address.
- bus_error  output  1  sticky; set on MOC timeout.
- stack_error  output  1  sticky; set on CALL overflow or RET underflow.

Behaviour:
- Reset (dominates everything, including stall):
  - state_addr=0, ret_valid=0, return register=0.
  - Timeout counter=0, bus_error=0, stack_error=0.
- Stall: when stall=1 and reset=0, all registers hold; timeout counter does not advance.
- Otherwise, on each clock, state_addr <= next, where next is selected by ns_sel:
  - 000 INC: state_addr+1, modulo 2^STATE_W (1023 wraps to 0).
  - 001 JUMP: cr.
  - 010 DECODE: enc_state.
  - 011 COND: c = flags[cond_sel] ^ inv; next = c ? cr : state_addr+1.
  - 100 WAIT_MOC:
    - moc=1: next=cr, counter cleared.
    - moc=0 and counter < MOC_TIMEOUT-1: hold state_addr, counter+1.
    - moc=0 on the MOC_TIMEOUT-th waiting cycle: next=ERR_STATE, bus_error<=1, counter cleared.
  - 101 CALL:
    - ret_valid=0: return register <= state_addr+1 (wrapped), ret_valid<=1, next=cr.
    - ret_valid=1 (overflow): next=ERR_STATE, stack_error<=1, return register unchanged.
  - 110 RET:
    - ret_valid=1: next=return register, ret_valid<=0.
    - ret_valid=0 (underflow): next=ERR_STATE, stack_error<=1.
  - 111 RESTART: next=0; ret_valid<=0; counter cleared; sticky errors kept.
- Timeout counter is cleared whenever ns_sel != WAIT_MOC at a non-stalled edge.
- Latency: control fields are sampled for the current state_addr; the new address appears one clock later. Microstore output follows combinationally.
- Sticky errors clear only on reset.
- ERR_STATE is an ordinary address; its control word decides what follows.
- moc high on the first WAIT_MOC cycle: zero wait, next=cr in that cycle.
- Reset asserted mid-wait or mid-call: all state is discarded and the sequencer starts at 0 on the next edge.

Test Plan:
- Reset, then INC x3 -> state_addr 0,1,2,3; ret_valid=0, bus_error=0, stack_error=0.
- state_addr=1023 with INC -> 0.
- COND with cr=20, cond_sel=00, inv=0:
  - Z=1 -> 20.
  - Z=0 -> state+1.
  - inv=1, Z=1 -> state+1.
- WAIT_MOC with cr=13 entered at state 12:
  - moc low 3 cycles then high -> state_addr stays 12 for 3 cycles with moc_wait=1, then 13.
  - moc never high, MOC_TIMEOUT=16 -> 48 after the 16th cycle, bus_error=1.
- CALL cr=40 at state 25 -> 40, ret_valid=1. RET -> 26, ret_valid=0. Second RET -> 48, stack_error=1. CALL while ret_valid=1 -> 48, stack_error=1.
- Stall 5 cycles during WAIT_MOC with moc=0 and MOC_TIMEOUT=16 -> counter frozen, timeout still fires after 16 non-stalled cycles.
- Reset asserted together with stall -> state_addr=0 next edge.

Source files
------------

// File: rtl/microsequencer.sv
// Microstore address sequencer: holds the current control-store address and
// selects the next one from the control word's next-state fields.
module microsequencer #(
  parameter int                 STATE_W     = 10,
  parameter logic [STATE_W-1:0] ERR_STATE   = 10'd48,
  parameter int                 MOC_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [2:0]         ns_sel,
  input  logic [STATE_W-1:0] cr,
  input  logic [1:0]         cond_sel,
  input  logic               inv,
  input  logic [3:0]         flags,
  input  logic [STATE_W-1:0] enc_state,
  input  logic               moc,
  output logic [STATE_W-1:0] state_addr,
  output logic               moc_wait,
  output logic               ret_valid,
  output logic               bus_error,
  output logic               stack_error
);

  typedef enum logic [2:0] {
    NsInc     = 3'b000,
    NsJump    = 3'b001,
    NsDecode  = 3'b010,
    NsCond    = 3'b011,
    NsWaitMoc = 3'b100,
    NsCall    = 3'b101,
    NsRet     = 3'b110,
    NsRestart = 3'b111
  } nsSelE;

  // Counter value on the last permitted waiting cycle; the next miss times out.
  localparam logic [7:0] MocLast = 8'(MOC_TIMEOUT - 1);

  nsSelE              nsCode;
  logic [STATE_W-1:0] incAddr;
  logic               condTrue;

  logic [STATE_W-1:0] stateAddr_q, stateAddr_d;
  logic [STATE_W-1:0] retAddr_q, retAddr_d;
  logic               retValid_q, retValid_d;
  logic [7:0]         mocCount_q, mocCount_d;
  logic               busError_q, busError_d;
  logic               stackError_q, stackError_d;

  assign nsCode   = nsSelE'(ns_sel);
  assign incAddr  = stateAddr_q + 1'b1;
  assign condTrue = flags[cond_sel] ^ inv;

  always_comb begin
    stateAddr_d  = stateAddr_q;
    retAddr_d    = retAddr_q;
    retValid_d   = retValid_q;
    mocCount_d   = '0;
    busError_d   = busError_q;
    stackError_d = stackError_q;
    unique case (nsCode)
      NsInc:    stateAddr_d = incAddr;
      NsJump:   stateAddr_d = cr;
      NsDecode: stateAddr_d = enc_state;
      NsCond:   stateAddr_d = condTrue ? cr : incAddr;
      NsWaitMoc: begin
        if (moc) begin
          stateAddr_d = cr;
        end else if (mocCount_q < MocLast) begin
          mocCount_d = mocCount_q + 8'd1;
        end else begin
          stateAddr_d = ERR_STATE;
          busError_d  = 1'b1;
        end
      end
      NsCall: begin
        if (retValid_q) begin
          stateAddr_d  = ERR_STATE;
          stackError_d = 1'b1;
        end else begin
          retAddr_d   = incAddr;
          retValid_d  = 1'b1;
          stateAddr_d = cr;
        end
      end
      NsRet: begin
        if (retValid_q) begin
          stateAddr_d = retAddr_q;
          retValid_d  = 1'b0;
        end else begin
          stateAddr_d  = ERR_STATE;
          stackError_d = 1'b1;
        end
      end
      NsRestart: begin
        stateAddr_d = '0;
        retValid_d  = 1'b0;
      end
      default: stateAddr_d = stateAddr_q;
    endcase
  end

  // Reset wins over stall; a stall freezes every register including the wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateAddr_q  <= '0;
      retAddr_q    <= '0;
      retValid_q   <= 1'b0;
      mocCount_q   <= '0;
      busError_q   <= 1'b0;
      stackError_q <= 1'b0;
    end else if (!stall) begin
      stateAddr_q  <= stateAddr_d;
      retAddr_q    <= retAddr_d;
      retValid_q   <= retValid_d;
      mocCount_q   <= mocCount_d;
      busError_q   <= busError_d;
      stackError_q <= stackError_d;
    end
  end

  assign state_addr  = stateAddr_q;
  assign ret_valid   = retValid_q;
  assign bus_error   = busError_q;
  assign stack_error = stackError_q;
  assign moc_wait    = (nsCode == NsWaitMoc) && !moc && !stall;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: directed test-plan sequences followed by
// random control words, checked against an integer-level reference model.
module tb_microsequencer;

  localparam int STATE_W     = 10;
  localparam int ERR_ADDR    = 48;
  localparam int MOC_TIMEOUT = 16;
  localparam int ADDR_MOD    = 1 << STATE_W;

  logic               clk = 1'b0;
  logic               reset, stall, inv, moc;
  logic [2:0]         ns_sel;
  logic [STATE_W-1:0] cr, enc_state;
  logic [1:0]         cond_sel;
  logic [3:0]         flags;
  logic [STATE_W-1:0] state_addr;
  logic               moc_wait, ret_valid, bus_error, stack_error;

  microsequencer #(
    .STATE_W(STATE_W),
    .ERR_STATE(10'd48),
    .MOC_TIMEOUT(MOC_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .ns_sel(ns_sel),
    .cr(cr),
    .cond_sel(cond_sel),
    .inv(inv),
    .flags(flags),
    .enc_state(enc_state),
    .moc(moc),
    .state_addr(state_addr),
    .moc_wait(moc_wait),
    .ret_valid(ret_valid),
    .bus_error(bus_error),
    .stack_error(stack_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit retValid;
    bit busErr;
    bit stackErr;
  } seqExpT;

  seqExpT seqQ[$];
  bit     combQ[$];

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as plain integers.
  int  mPc = 0;
  int  mRetAddr = 0;
  bit  mRetValid = 0;
  int  mWaited = 0;
  bit  mBusErr = 0;
  bit  mStackErr = 0;

  // Drive one control word at the falling edge and predict what follows.
  task automatic applyStimulus(input bit rst, input bit stl, input int ns, input int crV,
                               input int cs, input bit iv, input int fl, input int enc,
                               input bit mc);
    seqExpT e;
    bit c;
    @(negedge clk);
    reset = rst; stall = stl; ns_sel = 3'(ns); cr = STATE_W'(crV);
    cond_sel = 2'(cs); inv = iv; flags = 4'(fl); enc_state = STATE_W'(enc); moc = mc;
    combQ.push_back((ns == 4) && !mc && !stl);
    if (rst) begin
      mPc = 0; mRetAddr = 0; mRetValid = 0; mWaited = 0; mBusErr = 0; mStackErr = 0;
    end else if (!stl) begin
      case (ns)
        0: mPc = (mPc + 1) % ADDR_MOD;
        1: mPc = crV;
        2: mPc = enc;
        3: begin
          c = (((fl >> cs) & 1) != 0) ^ iv;
          mPc = c ? crV : (mPc + 1) % ADDR_MOD;
        end
        4: begin
          if (mc) begin
            mPc = crV; mWaited = 0;
          end else if (mWaited + 1 < MOC_TIMEOUT) begin
            mWaited++;
          end else begin
            mPc = ERR_ADDR; mBusErr = 1; mWaited = 0;
          end
        end
        5: begin
          if (mRetValid) begin
            mPc = ERR_ADDR; mStackErr = 1;
          end else begin
            mRetAddr = (mPc + 1) % ADDR_MOD; mRetValid = 1; mPc = crV;
          end
        end
        6: begin
          if (mRetValid) begin
            mPc = mRetAddr; mRetValid = 0;
          end else begin
            mPc = ERR_ADDR; mStackErr = 1;
          end
        end
        default: begin
          mPc = 0; mRetValid = 0;
        end
      endcase
      if (ns != 4) mWaited = 0;
    end
    e.pc = mPc; e.retValid = mRetValid; e.busErr = mBusErr; e.stackErr = mStackErr;
    seqQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Registered outputs: compared just after each rising edge.
  initial begin
    seqExpT e;
    forever begin
      @(posedge clk);
      #1;
      if (seqQ.size() > 0) begin
        e = seqQ.pop_front();
        checkOutput("state_addr", int'(state_addr), e.pc);
        checkOutput("ret_valid", int'(ret_valid), int'(e.retValid));
        checkOutput("bus_error", int'(bus_error), int'(e.busErr));
        checkOutput("stack_error", int'(stack_error), int'(e.stackErr));
      end
    end
  end

  // Combinational moc_wait: compared mid-cycle once inputs have settled.
  initial begin
    bit exp;
    forever begin
      @(negedge clk);
      #2;
      if (combQ.size() > 0) begin
        exp = combQ.pop_front();
        checkOutput("moc_wait", int'(moc_wait), int'(exp));
      end
    end
  end

  task automatic simple(input int ns, input int crV);
    applyStimulus(0, 0, ns, crV, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; stall = 0; ns_sel = 0; cr = 0; cond_sel = 0; inv = 0;
    flags = 0; enc_state = 0; moc = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) simple(0, 0);
    simple(1, 1023);
    simple(0, 0);
    simple(2, 0);
    applyStimulus(0, 0, 2, 0, 0, 0, 0, 777, 0);

    simple(1, 5);
    applyStimulus(0, 0, 3, 20, 0, 0, 4'b0001, 0, 0);
    applyStimulus(0, 0, 3, 20, 0, 0, 4'b0000, 0, 0);
    applyStimulus(0, 0, 3, 20, 0, 1, 4'b0001, 0, 0);
    applyStimulus(0, 0, 3, 300, 3, 0, 4'b1000, 0, 0);

    simple(1, 12);
    repeat (3) applyStimulus(0, 0, 4, 13, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 4, 13, 0, 0, 0, 0, 1);
    simple(1, 12);
    applyStimulus(0, 0, 4, 13, 0, 0, 0, 0, 1);
    simple(1, 12);
    repeat (MOC_TIMEOUT) applyStimulus(0, 0, 4, 13, 0, 0, 0, 0, 0);

    simple(1, 25);
    simple(5, 40);
    simple(6, 0);
    simple(6, 0);
    simple(5, 40);
    simple(5, 40);
    simple(7, 0);

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    simple(1, 12);
    repeat (8) applyStimulus(0, 0, 4, 13, 0, 0, 0, 0, 0);
    repeat (5) applyStimulus(0, 1, 4, 13, 0, 0, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 4, 13, 0, 0, 0, 0, 0);
    simple(1, 30);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7), $urandom_range(0, ADDR_MOD - 1),
                    $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 15),
                    $urandom_range(0, ADDR_MOD - 1), $urandom_range(0, 9) == 0);
    end

    repeat (3) @(posedge clk);
    #3;
    checkOutput("scoreboard_drained", seqQ.size() + combQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
